// File: rtl/screen_sequencer_pkg.sv
// Shared types for the screen sequencer: FSM states, the screen codes seen by the
// VGA output mux, and the state-to-screen mapping.
package screen_sequencer_pkg;

   typedef enum logic [1:0] {
      SCR_TITLE = 2'd0,
      SCR_PLAY  = 2'd1,
      SCR_WIN   = 2'd2,
      SCR_LOSE  = 2'd3
   } screen_t;

   typedef enum logic [2:0] {
      ST_TITLE,
      ST_CLEAR,
      ST_SYNC,
      ST_PLAY,
      ST_WIN,
      ST_LOSE
   } state_t;

   // CLEAR and SYNC keep the title artwork up until play actually begins.
   function automatic screen_t state_screen(input state_t s);
      screen_t scr;
      case (s)
         ST_PLAY: scr = SCR_PLAY;
         ST_WIN:  scr = SCR_WIN;
         ST_LOSE: scr = SCR_LOSE;
         default: scr = SCR_TITLE;
      endcase
      return scr;
   endfunction

endpackage

// File: rtl/screen_sequencer_edge_rise.sv
// Registered rising-edge detector: pulse is high for one cycle after a cycle in which
// din=1 and the previous din=0.
module screen_sequencer_edge_rise (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse
);

   logic r_prev;
   logic r_pulse;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev  <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_prev  <= din;
         r_pulse <= din & ~r_prev;
      end
   end

   assign pulse = r_pulse;

endmodule

// File: rtl/screen_sequencer.sv
// Game screen controller: TITLE -> PLAY -> WIN/LOSE -> TITLE, screen changes aligned to vblank.
// Define SCREEN_SEQ_AUTO_RETURN_EN to let WIN/LOSE fall back to TITLE after AUTO_FRAMES.
module screen_sequencer
   import screen_sequencer_pkg::*;
#(
   parameter int END_HOLD_FRAMES = 180,
   parameter int AUTO_FRAMES     = 600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vblnk,
   input  logic       button_start,
   input  logic       game_won,
   input  logic       game_lost,
   output logic       game_start,
   output logic       game_rst,
   output logic [1:0] screen_sel,
   output logic       frame_tick
);

   localparam int HOLD_W = $clog2(AUTO_FRAMES + 1);
`ifdef SCREEN_SEQ_AUTO_RETURN_EN
   localparam int HOLD_MAX = AUTO_FRAMES;
   localparam logic [HOLD_W-1:0] AUTO_C = HOLD_W'(AUTO_FRAMES);
`else
   localparam int HOLD_MAX = END_HOLD_FRAMES;
`endif
   localparam logic [HOLD_W-1:0] END_C      = HOLD_W'(END_HOLD_FRAMES);
   localparam logic [HOLD_W-1:0] HOLD_MAX_C = HOLD_W'(HOLD_MAX);
   localparam logic [HOLD_W-1:0] ONE_C      = HOLD_W'(1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic              w_hold_done;
   logic              w_in_end;
   logic              w_frame_tick;
   logic              w_press;
   logic              r_game_start;
   logic              r_game_rst;
   logic [1:0]        r_screen_sel;

   screen_sequencer_edge_rise u_vblnk_edge (
      .clk   (clk),
      .rst   (rst),
      .din   (vblnk),
      .pulse (w_frame_tick)
   );

   screen_sequencer_edge_rise u_button_edge (
      .clk   (clk),
      .rst   (rst),
      .din   (button_start),
      .pulse (w_press)
   );

   assign w_in_end = (r_state == ST_WIN) || (r_state == ST_LOSE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_TITLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_hold_done = (r_hold_cnt >= END_C);
      case (r_state)
         ST_TITLE: begin
            if (w_press) w_state_nxt = ST_CLEAR;
         end
         ST_CLEAR: begin
            w_state_nxt = ST_SYNC;
         end
         ST_SYNC: begin
            if (w_frame_tick) w_state_nxt = ST_PLAY;
         end
         ST_PLAY: begin
            // A simultaneous win and loss resolves as a loss.
            if (game_lost)     w_state_nxt = ST_LOSE;
            else if (game_won) w_state_nxt = ST_WIN;
         end
         ST_WIN, ST_LOSE: begin
            if (w_press && w_hold_done) w_state_nxt = ST_TITLE;
`ifdef SCREEN_SEQ_AUTO_RETURN_EN
            else if (r_hold_cnt >= AUTO_C) w_state_nxt = ST_TITLE;
`endif
         end
         default: begin
            w_state_nxt = ST_TITLE;
         end
      endcase
   end

   // Counter is zero everywhere outside WIN/LOSE, so it starts fresh on every entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold_cnt <= '0;
      end else if (!w_in_end) begin
         r_hold_cnt <= '0;
      end else if (w_frame_tick && (r_hold_cnt != HOLD_MAX_C)) begin
         r_hold_cnt <= r_hold_cnt + ONE_C;
      end
   end

   // Outputs decode the next state so they line up with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_game_start <= 1'b0;
         r_game_rst   <= 1'b0;
         r_screen_sel <= SCR_TITLE;
      end else begin
         r_game_start <= (w_state_nxt == ST_PLAY);
         r_game_rst   <= (w_state_nxt == ST_CLEAR);
         if (w_frame_tick) r_screen_sel <= state_screen(w_state_nxt);
      end
   end

   assign game_start = r_game_start;
   assign game_rst   = r_game_rst;
   assign screen_sel = r_screen_sel;
   assign frame_tick = w_frame_tick;

endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench for screen_sequencer: a frame-level game model predicts every cycle's
// outputs, a separate monitor compares them against the DUT.
module tb_screen_sequencer;

   localparam int END_HOLD = 4;
   localparam int AUTO     = 8;

   localparam int P_TITLE = 0, P_CLEAR = 1, P_SYNC = 2, P_PLAY = 3, P_WIN = 4, P_LOSE = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vblnk = 1'b0;
   logic       button_start = 1'b0;
   logic       game_won = 1'b0;
   logic       game_lost = 1'b0;
   logic       game_start;
   logic       game_rst;
   logic [1:0] screen_sel;
   logic       frame_tick;

   screen_sequencer #(
      .END_HOLD_FRAMES (END_HOLD),
      .AUTO_FRAMES     (AUTO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .vblnk        (vblnk),
      .button_start (button_start),
      .game_won     (game_won),
      .game_lost    (game_lost),
      .game_start   (game_start),
      .game_rst     (game_rst),
      .screen_sel   (screen_sel),
      .frame_tick   (frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       start;
      logic       grst;
      logic [1:0] sel;
      logic       tick;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   bit   in_reset = 1'b1;

   // Reference model: what the player sees, tracked frame by frame.
   int   m_phase, m_frames;
   bit   m_tick, m_press, m_prev_v, m_prev_b, m_start, m_grst;
   logic [1:0] m_sel;
   int   fcnt = 0, flen = 16;

   function automatic logic [1:0] screen_of(input int ph);
      if (ph == P_PLAY) return 2'd1;
      if (ph == P_WIN)  return 2'd2;
      if (ph == P_LOSE) return 2'd3;
      return 2'd0;
   endfunction

   task automatic model_reset();
      m_phase = P_TITLE; m_frames = 0;
      m_tick = 0; m_press = 0; m_prev_v = 0; m_prev_b = 0;
      m_start = 0; m_grst = 0; m_sel = 2'd0;
   endtask

   task automatic model_step(input bit v, input bit b, input bit w, input bit l);
      int nxt;
      int cap;
      bit at_end;
      nxt = m_phase;
      at_end = (m_phase == P_WIN) || (m_phase == P_LOSE);
`ifdef SCREEN_SEQ_AUTO_RETURN_EN
      cap = AUTO;
`else
      cap = END_HOLD;
`endif
      if (m_phase == P_TITLE && m_press) nxt = P_CLEAR;
      else if (m_phase == P_CLEAR) nxt = P_SYNC;
      else if (m_phase == P_SYNC && m_tick) nxt = P_PLAY;
      else if (m_phase == P_PLAY) nxt = l ? P_LOSE : (w ? P_WIN : P_PLAY);
      else if (at_end) begin
         if (m_press && m_frames >= END_HOLD) nxt = P_TITLE;
`ifdef SCREEN_SEQ_AUTO_RETURN_EN
         else if (m_frames >= AUTO) nxt = P_TITLE;
`endif
      end
      if (!at_end) m_frames = 0;
      else if (m_tick && m_frames < cap) m_frames++;
      if (m_tick) m_sel = screen_of(nxt);
      m_start = (nxt == P_PLAY);
      m_grst  = (nxt == P_CLEAR);
      m_phase = nxt;
      m_tick  = v && !m_prev_v;
      m_press = b && !m_prev_b;
      m_prev_v = v;
      m_prev_b = b;
   endtask

   task automatic gen_v(output bit v);
      fcnt++;
      if (fcnt >= flen) begin
         fcnt = 0;
         flen = $urandom_range(12, 22);
      end
      v = (fcnt >= flen - 3);
   endtask

   // Called at a negedge: apply inputs for the next posedge, predict, then wait a cycle.
   task automatic drive(input bit b, input bit w, input bit l);
      bit   v;
      exp_t e;
      gen_v(v);
      vblnk = v; button_start = b; game_won = w; game_lost = l;
      model_step(v, b, w, l);
      e.start = m_start; e.grst = m_grst; e.sel = m_sel; e.tick = m_tick;
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if ({game_start, game_rst, screen_sel, frame_tick} !== 5'b0) begin
         errors++;
         $display("FAIL %s start=%0b rst=%0b sel=%0d tick=%0b, required all zero",
                  name, game_start, game_rst, screen_sel, frame_tick);
      end
   endtask

   task automatic do_reset();
      in_reset = 1'b1;
      q.delete();
      #3 rst = 1'b1;
      #1 check_reset_outputs("async_reset_mid_game");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      in_reset = 1'b0;
   endtask

   task automatic idle(input int n, input bit b);
      for (int i = 0; i < n; i++) drive(b, 1'b0, 1'b0);
   endtask

   task automatic press(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle_until_phase(input int ph, input int max_cyc, input bit b);
      for (int i = 0; i < max_cyc && m_phase != ph; i++) drive(b, 1'b0, 1'b0);
   endtask

   task automatic idle_until_frames(input int f, input int max_cyc);
      for (int i = 0; i < max_cyc && m_frames < f; i++) drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic to_play();
      idle_until_phase(P_TITLE, 400, 1'b0);
      press(3);
      idle_until_phase(P_PLAY, 80, 1'b0);
   endtask

   // Monitor: every cycle out of reset is a presented output to compare.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!in_reset) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_empty t=%0t got sel=%0d, required a queued prediction",
                        $time, screen_sel);
            end else begin
               e = q.pop_front();
               if ({game_start, game_rst, screen_sel, frame_tick} !== e) begin
                  errors++;
                  $display("FAIL outputs t=%0t got start=%0b rst=%0b sel=%0d tick=%0b required start=%0b rst=%0b sel=%0d tick=%0b",
                           $time, game_start, game_rst, screen_sel, frame_tick,
                           e.start, e.grst, e.sel, e.tick);
               end
            end
         end
      end
   end

   initial begin : stimulus
      bit b;
      int resets;
      model_reset();
      @(negedge clk);
      check_reset_outputs("reset_state");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      in_reset = 1'b0;

      // Idle title screen for a few frames.
      idle(60, 1'b0);

      // Start key held 10 cycles, then wait for play.
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0);
      idle(40, 1'b0);
      idle_until_phase(P_PLAY, 80, 1'b0);

      // Win and loss together.
      drive(1'b0, 1'b1, 1'b1);
      idle(40, 1'b0);
      idle_until_frames(END_HOLD, 200);
      press(2);

      // Early press ignored in WIN, later press accepted.
      to_play();
      drive(1'b0, 1'b1, 1'b0);
      idle_until_frames(2, 100);
      press(2);
      idle_until_frames(5, 200);
      press(2);
      idle(40, 1'b0);

      // Key held through PLAY into WIN, then release and re-press.
      to_play();
      idle(3, 1'b1);
      drive(1'b1, 1'b1, 1'b0);
      idle(200, 1'b1);
      idle(5, 1'b0);
      press(3);
      idle(40, 1'b0);

      // Reset while playing.
      to_play();
      idle(7, 1'b0);
      if (m_phase == P_PLAY) do_reset();
      idle(30, 1'b0);

      // Sit in WIN with no key.
      to_play();
      drive(1'b0, 1'b1, 1'b0);
      idle(260, 1'b0);

      // Random play.
      b = 1'b0;
      resets = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) b = ~b;
         drive(b, ($urandom_range(0, 59) == 0), ($urandom_range(0, 79) == 0));
         if (i > 500 && resets < 3 && m_phase == P_PLAY && $urandom_range(0, 99) == 0) begin
            do_reset();
            resets++;
         end
      end

      idle(5, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
